// File: rtl/motor_ramp_seq_if.sv
// Command channel into motor_ramp_seq: a signed left/right speed target pair
// moved over a valid/ready handshake.
// Ports: tgt_lft/tgt_rht (11-bit signed targets), cmd_vld (pair valid), cmd_rdy (sink ready).
interface motor_ramp_seq_if;
  logic signed [10:0] tgt_lft;
  logic signed [10:0] tgt_rht;
  logic               cmd_vld;
  logic               cmd_rdy;

  modport master (output tgt_lft, tgt_rht, cmd_vld, input cmd_rdy);
  modport slave  (input tgt_lft, tgt_rht, cmd_vld, output cmd_rdy);
endinterface

// File: rtl/motor_ramp_seq.sv
// Slew-rate sequencer in front of motor_cntrl: walks signed lft/rht drive
// values toward commanded targets by STEP every TICK_DIV clocks, with estop.
// Ports: clk, rst_n (async active-low), cmd (target handshake, slave side),
//   estop (level), lft/rht (registered drive), busy (not idle), at_tgt (idle and settled).
// Optional: define MTR_REV_DWELL_EN to force a stop at zero on reversal and
//   hold there for DWELL_TICKS ticks before ramping the other way.
module motor_ramp_seq #(
  parameter int STEP        = 8,
  parameter int TICK_DIV    = 1024,
  parameter int DWELL_TICKS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  motor_ramp_seq_if.slave    cmd,
  input  logic               estop,
  output logic signed [10:0] lft,
  output logic signed [10:0] rht,
  output logic               busy,
  output logic               at_tgt
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic signed [11:0] STEP_P = 12'(STEP);
  localparam logic signed [11:0] STEP_N = -12'(STEP);

  if (STEP < 1 || STEP > 255 || TICK_DIV < 2 || DWELL_TICKS < 1) begin : g_param_err
    $error("motor_ramp_seq: illegal parameter value");
  end

`ifdef MTR_REV_DWELL_EN
  typedef enum logic [1:0] {IDLE, RAMP, DWELL, ESTOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RAMP, ESTOP} state_t;
`endif

  state_t             state;
  logic [TW-1:0]      tick_cnt;
  logic               tick;
  logic               accept;
  logic signed [10:0] tgt_l, tgt_r;
  logic signed [10:0] cmd_l, cmd_r;
  logic signed [10:0] nxt_l, nxt_r;

  // -1024 has no magnitude representation in motor_cntrl's 10-bit field.
  function automatic logic signed [10:0] sat11(input logic signed [10:0] v);
    return (v == 11'sh400) ? 11'sh401 : v;
  endfunction

`ifdef MTR_REV_DWELL_EN
  // Output moving and target on the other side of zero.
  function automatic logic reversing(input logic signed [10:0] cur,
                                     input logic signed [10:0] tgt);
    return (cur != '0) && (tgt != '0) && (cur[10] != tgt[10]);
  endfunction
`endif

  // One ramp step toward the goal; 12-bit math covers the full +-2046 span.
  function automatic logic signed [10:0] ramp_step(input logic signed [10:0] cur,
                                                   input logic signed [10:0] tgt);
    logic signed [11:0] cur_x, goal, diff, nxt;
    cur_x = {cur[10], cur};
    goal  = {tgt[10], tgt};
`ifdef MTR_REV_DWELL_EN
    if (reversing(cur, tgt)) goal = '0;
`endif
    diff = goal - cur_x;
    if (diff > STEP_P)      nxt = cur_x + STEP_P;
    else if (diff < STEP_N) nxt = cur_x - STEP_P;
    else                    nxt = goal;
    return nxt[10:0];
  endfunction

  assign cmd.cmd_rdy = (state != ESTOP) & ~estop;
  assign accept      = cmd.cmd_vld & cmd.cmd_rdy;
  assign cmd_l       = sat11(cmd.tgt_lft);
  assign cmd_r       = sat11(cmd.tgt_rht);
  assign nxt_l       = ramp_step(lft, tgt_l);
  assign nxt_r       = ramp_step(rht, tgt_r);

  // Free-running tick divider; deliberately independent of commands and estop.
  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

`ifdef MTR_REV_DWELL_EN
  localparam int DW_W = $clog2(DWELL_TICKS + 1);
  logic [DW_W-1:0] dwell_cnt;
  logic            rev_land;
  // A channel reaches zero this tick because its goal was clamped for reversal.
  assign rev_land = (reversing(lft, tgt_l) && nxt_l == '0) ||
                    (reversing(rht, tgt_r) && nxt_r == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lft    <= '0;
      rht    <= '0;
      tgt_l  <= '0;
      tgt_r  <= '0;
      busy   <= 1'b0;
      at_tgt <= 1'b1;
`ifdef MTR_REV_DWELL_EN
      dwell_cnt <= '0;
`endif
    end else if (estop) begin
      // Estop overrides everything, including a command on the same edge.
      state  <= ESTOP;
      lft    <= '0;
      rht    <= '0;
      tgt_l  <= '0;
      tgt_r  <= '0;
      busy   <= 1'b1;
      at_tgt <= 1'b0;
    end else begin
      if (accept) begin
        tgt_l <= cmd_l;
        tgt_r <= cmd_r;
      end
      case (state)
        IDLE: begin
          if (accept && (cmd_l != lft || cmd_r != rht)) begin
            state  <= RAMP;
            busy   <= 1'b1;
            at_tgt <= 1'b0;
          end
        end
        RAMP: begin
          // A fresh accept may carry new targets, so only settle without one.
          if (!accept && lft == tgt_l && rht == tgt_r) begin
            state  <= IDLE;
            busy   <= 1'b0;
            at_tgt <= 1'b1;
          end else if (tick) begin
            // Steps use the targets latched before this edge.
            lft <= nxt_l;
            rht <= nxt_r;
`ifdef MTR_REV_DWELL_EN
            if (rev_land) begin
              state     <= DWELL;
              dwell_cnt <= '0;
            end
`endif
          end
        end
`ifdef MTR_REV_DWELL_EN
        DWELL: begin
          if (tick) begin
            if (dwell_cnt == DW_W'(DWELL_TICKS - 1)) state <= RAMP;
            else dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
`endif
        ESTOP: begin
          // estop is low here; outputs and targets are already zero.
          state  <= IDLE;
          busy   <= 1'b0;
          at_tgt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/motor_ramp_seq.md
# motor_ramp_seq

Slew-rate sequencer that sits between the command source (remote/navigation logic) and `motor_cntrl`. It accepts signed left/right speed targets over a valid/ready handshake. It walks the signed 11-bit `lft`/`rht` drive values toward those targets in fixed steps at a divided tick rate. It also enforces a stop-through-zero on direction reversal and an emergency stop, so the PWM stage never sees step changes.

## Interface
- `STEP`, 8: magnitude change per tick, legal 1..255
- `TICK_DIV`, 1024: clocks per ramp tick, legal ≥2
- `DWELL_TICKS`, 16: ticks held at zero on reversal, legal ≥1 (used only with `MTR_REV_DWELL_EN`)

- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `tgt_lft` in 11: signed two's-complement left target
- `tgt_rht` in 11: signed two's-complement right target
- `cmd_vld` in 1: target pair valid
- `cmd_rdy` out 1: combinational, `(state != ESTOP) & ~estop`
- `estop` in 1: emergency stop, level-sensitive
- `lft` out 11: signed left drive to `motor_cntrl`, registered
- `rht` out 11: signed right drive to `motor_cntrl`, registered
- `busy` out 1: registered, `state != IDLE`
- `at_tgt` out 1: registered, high in IDLE when `lft`/`rht` equal the latched targets

## Operation
- FSM states: IDLE, RAMP, DWELL, ESTOP.
- Handshake:
  - A command is accepted on an edge where `cmd_vld & cmd_rdy` is high.
  - Both targets are latched, saturated to -1023..+1023. -1024 becomes -1023 because the `motor_cntrl` magnitude field is 10 bits.
  - Accepted in IDLE, RAMP, and DWELL. A new command replaces the targets, and ramping continues from the current outputs.
- IDLE→RAMP: on accept when either latched target differs from its output. An accept of equal targets stays in IDLE.
- Tick counter:
  - Free-running, counts 0..TICK_DIV-1. `tick` is high when the count equals TICK_DIV-1, then wraps.
  - Not cleared by commands or by estop.
- RAMP, on each tick, per channel, using goal g:
  - g = 0 if the output is nonzero and the target has the opposite nonzero sign; otherwise g = target.
  - If |g − cur| ≤ STEP, cur = g; otherwise cur moves STEP toward g.
  - Use 12-bit internal difference arithmetic; no overflow is permitted.
- RAMP→IDLE: on the edge after both outputs equal their targets.
- RAMP→DWELL: on a tick where any channel lands on 0 via a reversal goal (macro enabled). DWELL freezes both channels for DWELL_TICKS ticks, then returns to RAMP.
- Estop:
  - When `estop` is sampled high in any state, the next edge sets `lft = rht = 0`, targets to 0, and state ESTOP.
  - Estop beats a simultaneous command; that command is not accepted.
  - ESTOP holds while `estop` is high. The first edge with `estop` low goes to IDLE.
- Reset values:
  - `lft = rht = 0`, targets 0, tick count 0, dwell count 0, state IDLE.
  - `busy = 0`, `at_tgt = 1`, `cmd_rdy = 1` once `rst_n` is released.

## Timing
- `lft`/`rht` change only on edges where `tick` = 1, except the estop clear, which takes one edge.
- After reset, the first tick edge is clock TICK_DIV.
- Command latency: a command accepted at edge N moves the outputs at the first tick edge after N.
- `busy` goes high the edge after accept. `at_tgt` goes high and `busy` goes low the edge after the final step lands.
- A tick and an accept on the same edge: that tick uses the old targets, and the new targets apply from the next tick.
- A dwell count of DWELL_TICKS means exactly DWELL_TICKS tick edges with frozen outputs.
- Asserting `rst_n` mid-ramp returns immediately to the reset values.

## Configuration
- `MTR_REV_DWELL_EN` defined: the reversal goal is forced to 0, and the DWELL state is implemented as described.
- Not defined:
  - No zero goal; a reversal ramps straight through zero, and a step may cross zero (e.g. +4 → -4).
  - DWELL state and dwell counter are absent.
  - Parameter `DWELL_TICKS` is ignored.

## Test plan
- Nominal ramp (STEP=8, TICK_DIV=4): from reset, accept lft=+20, rht=-20 → lft 8,16,20 and rht -8,-16,-20 on ticks 1-3 → `busy` falls, `at_tgt` rises one edge later.
- Saturation: accept lft=-1024 (11'h400) → ramps to and holds -1023; `at_tgt`=1.
- Reversal with macro (DWELL_TICKS=2): lft at +12, accept -12 → ticks give 4, 0, 0, 0, -8, -12. Without the macro: 4, -4, -12.
- Estop mid-ramp: lft=+16 heading to +40, raise `estop` → next edge lft=rht=0, `cmd_rdy`=0, command ignored. Release → IDLE, `at_tgt`=1.
- Retarget: during ramp at +16 toward +100, accept +20 → next tick 20, then IDLE.
- Estop and `cmd_vld` on the same cycle → command not accepted, outputs 0.
